mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the single-cycle core's data bus, in parallel with dmem.
- Consumes the core's store traffic (MemWrite, ALUResult address, WriteData) and buffers bytes in a small FIFO.
- Serialises buffered bytes 8N1 on a tx pin.
- Supplies a combinational status read word that top muxes into ReadData when the address decodes.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..64.
- BASE_ADDR, 32'h0000_1000: register block base; 8-byte aligned.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- we  input  1  store strobe from core (MemWrite).
- a  input  32  byte address from core (ALUResult).
- wd  input  32  store data from core (WriteData).
- rd  output  32  combinational read data; 0 when the address is not decoded.
- tx  output  1  serial line, idle high.

Behaviour:
- Decode:
  - hit = (a[31:3] == BASE_ADDR[31:3]); a[1:0] ignored.
  - a[2]=0 is TXDATA; a[2]=1 is STATUS.
- TXDATA:
  - we&hit&~a[2] pushes wd[7:0]; wd[31:8] ignored.
  - Reads return 0.
- STATUS read:
  - [0] full.
  - [1] empty.
  - [2] busy (FSM not IDLE).
  - [3] overflow (sticky).
  - [4] parity_en (see Optional Feature).
  - [15:8] FIFO count, zero-extended.
  - All other bits 0.
- STATUS write: if wd[3]=1, clear overflow; all other bits ignored.
- rd:
  - Purely combinational from a and the state registers.
  - 0 for any non-hit address; the core reads it in the same cycle.
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Wrap-around is modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- Push while full:
  - Byte dropped; overflow set on that edge.
  - This holds even if a pop occurs in the same cycle (full is evaluated on the pre-edge count).
- Simultaneous push and pop (not full): both occur; count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If ~empty at the edge, pop the head into shift register sh[7:0], load bit counter baud_cnt=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles, then shift right. After bit_idx=7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between frames when the FIFO is non-empty.
- Latency:
  - A push on edge N into an empty FIFO with the FSM in IDLE pops on edge N+1; tx falls after edge N+1.
  - A frame occupies 10*CLKS_PER_BIT cycles from the start bit to the end of the stop bit.
- tx is registered; no glitches.
- Reset (async, any time, including mid-frame or mid-push):
  - tx=1, FSM=IDLE, FIFO emptied (pointers and count 0).
  - overflow=0, sh=0, counters=0.
  - rd then reads STATUS=0x0000_0002 (or 0x0000_0012 with the feature enabled).
  - No partial frame resumes after reset.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles.
  - STATUS[4] reads 1.
- Undefined:
  - 8N1 as above, 10*CLKS_PER_BIT cycles per frame.
  - STATUS[4] reads 0.
  - No parity logic is synthesised.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=0x1000, feature off unless stated):
- Single byte: assert and hold reset low, then release; read 0x1004 → rd=0x0000_0002, tx=1. Write 0x55 to 0x1000 → tx falls 1 cycle later. Line shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each for 4 cycles. busy=1 for 40 cycles, then STATUS=0x0000_0002.
- Overflow: 10 consecutive cycles writing 0x01..0x0A to 0x1000.
  - 0x01 pops immediately and 0x02..0x09 fill the FIFO (count=8, STATUS=0x0000_0805).
  - 0x0A is dropped, setting overflow (STATUS=0x0000_080D).
  - Serial output is 0x01..0x09 in order; 0x0A is never sent.
- Overflow clear: after the overflow test, write 0x0000_0008 to 0x1004 → STATUS[3]=0. A write of 0x0000_0000 to 0x1004 leaves a set overflow unchanged.
- Reset mid-frame: write 0xA5, 0x3C; assert reset during DATA bit 3 → tx=1 asynchronously, STATUS=0x0000_0002 after release, no further start bit.
- Decode: writes to 0x1008, 0x0FFC and 0x0000 with we=1 → no push, count stays 0. Reads of those addresses → rd=0. A read of 0x1006 returns STATUS (a[1:0] ignored).
- UART_PARITY_EN defined: write 0x07 → data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop. Frame is 44 cycles; STATUS=0x0000_0012 when idle.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TXDATA are queued in a small FIFO and sent 8N1 on tx.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    localparam logic PARITY_FLAG = 1'b0;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t        stateQ, stateD;
    logic [15:0]   baudCntQ, baudCntD;
    logic [2:0]    bitIdxQ, bitIdxD;
    logic [7:0]    shQ, shD;
    logic          txQ, txD;
    logic          overflowQ, overflowD;
    logic [PW-1:0] wrPtrQ, rdPtrQ;
    logic [CW-1:0] countQ, countD;
    logic [7:0]    mem [FIFO_DEPTH];
`ifdef UART_PARITY_EN
    logic          parityQ, parityD;
`endif

    logic hit, full, empty, busy, pushReq, doPush, pop, bitDone, clearOvf;
    logic unusedBits;

    assign hit        = (a[31:3] == BASE_ADDR[31:3]);
    assign full       = (countQ == CW'(FIFO_DEPTH));
    assign empty      = (countQ == '0);
    assign busy       = (stateQ != IDLE);
    assign pushReq    = we & hit & ~a[2];
    assign doPush     = pushReq & ~full;
    assign clearOvf   = we & hit & a[2] & wd[3];
    assign bitDone    = (baudCntQ == BAUD_LAST);
    assign unusedBits = ^{a[1:0], wd[31:8]};
    assign tx         = txQ;

    always_comb begin
        rd = '0;
        if (hit && a[2]) begin
            rd = {16'h0000, 8'(countQ), 3'b000, PARITY_FLAG, overflowQ, busy, empty, full};
        end
    end

    // A push that meets a full FIFO is lost even if the transmitter pops on the same edge.
    always_comb begin
        overflowD = overflowQ;
        if (pushReq && full) begin
            overflowD = 1'b1;
        end else if (clearOvf) begin
            overflowD = 1'b0;
        end
        countD = countQ;
        case ({doPush, pop})
            2'b10:   countD = countQ + CW'(1);
            2'b01:   countD = countQ - CW'(1);
            default: countD = countQ;
        endcase
    end

    always_comb begin
        stateD   = stateQ;
        baudCntD = baudCntQ;
        bitIdxD  = bitIdxQ;
        shD      = shQ;
        pop      = 1'b0;
`ifdef UART_PARITY_EN
        parityD  = parityQ;
`endif
        case (stateQ)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shD      = mem[rdPtrQ];
                    baudCntD = '0;
                    stateD   = START;
`ifdef UART_PARITY_EN
                    parityD  = ^mem[rdPtrQ];
`endif
                end
            end
            START: begin
                baudCntD = baudCntQ + 16'd1;
                if (bitDone) begin
                    baudCntD = '0;
                    bitIdxD  = '0;
                    stateD   = DATA;
                end
            end
            DATA: begin
                baudCntD = baudCntQ + 16'd1;
                if (bitDone) begin
                    baudCntD = '0;
                    shD      = {1'b0, shQ[7:1]};
                    if (bitIdxQ == 3'd7) begin
`ifdef UART_PARITY_EN
                        stateD = PARITY;
`else
                        stateD = STOP;
`endif
                    end else begin
                        bitIdxD = bitIdxQ + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                baudCntD = baudCntQ + 16'd1;
                if (bitDone) begin
                    baudCntD = '0;
                    stateD   = STOP;
                end
            end
`endif
            STOP: begin
                baudCntD = baudCntQ + 16'd1;
                if (bitDone) begin
                    baudCntD = '0;
                    stateD   = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase

        // The line level is decided from the next state so tx comes straight off a flop.
        case (stateD)
            START:   txD = 1'b0;
            DATA:    txD = shD[0];
`ifdef UART_PARITY_EN
            PARITY:  txD = parityD;
`endif
            default: txD = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= IDLE;
            baudCntQ  <= '0;
            bitIdxQ   <= '0;
            shQ       <= '0;
            txQ       <= 1'b1;
            overflowQ <= 1'b0;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            countQ    <= '0;
`ifdef UART_PARITY_EN
            parityQ   <= 1'b0;
`endif
        end else begin
            stateQ    <= stateD;
            baudCntQ  <= baudCntD;
            bitIdxQ   <= bitIdxD;
            shQ       <= shD;
            txQ       <= txD;
            overflowQ <= overflowD;
            countQ    <= countD;
            if (doPush) begin
                wrPtrQ <= wrPtrQ + PW'(1);
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + PW'(1);
            end
`ifdef UART_PARITY_EN
            parityQ   <= parityD;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrQ] <= wd[7:0];
        end
    end

endmodule
